// File: rtl/beacon_report_rx.sv
// Beacon report receiver: parses six-word report packets and commits
// their fields atomically once the packet is confirmed good.
module beacon_report_rx #(
    parameter logic [15:0] ETHERTYPE = 16'h1662,
    parameter logic [3:0]  RPT_TYPE  = 4'h3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [133:0] in_data,
    input  logic         in_data_wr,
    input  logic         in_data_valid,
    input  logic         in_data_valid_wr,
    output logic         pktin_ready,
    input  logic [47:0]  in_local_mac_id,
    output logic [47:0]  rpt_src_mac,
    output logic [47:0]  rpt_timestamp,
    output logic [63:0]  esw_pktin_cnt,
    output logic [63:0]  esw_pktout_cnt,
    output logic [63:0]  eos_mdin_cnt,
    output logic [63:0]  eos_mdout_cnt,
    output logic [63:0]  goe_pktin_cnt,
    output logic [63:0]  goe_port0out_cnt,
    output logic [63:0]  goe_port1out_cnt,
    output logic [63:0]  goe_discard_cnt,
    output logic [7:0]   bufm_id_cnt,
    output logic [5:0]   eos_q0_used_cnt,
    output logic [5:0]   eos_q1_used_cnt,
    output logic [5:0]   eos_q2_used_cnt,
    output logic [5:0]   eos_q3_used_cnt,
    output logic         rpt_update,
    output logic [31:0]  rpt_ok_cnt,
    output logic [31:0]  rpt_err_cnt
);

    typedef enum logic [2:0] {
        IDLE, RECV, WAIT_VALID, DISCARD, COMMIT
    } state_t;

    typedef struct packed {
        logic [47:0] smac;
        logic [47:0] ts;
        logic [63:0] esw_in;
        logic [63:0] esw_out;
        logic [63:0] eos_in;
        logic [63:0] eos_out;
        logic [63:0] goe_in;
        logic [63:0] goe_p0;
        logic [63:0] goe_p1;
        logic [63:0] goe_dis;
        logic [7:0]  bufm;
        logic [5:0]  q0;
        logic [5:0]  q1;
        logic [5:0]  q2;
        logic [5:0]  q3;
    } rpt_t;

    state_t       state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         bad_q, bad_d;
    rpt_t         stg_q, stg_d;
    rpt_t         rpt_q, rpt_d;
    logic [31:0]  ok_cnt_q, ok_cnt_d;
    logic [31:0]  err_cnt_q, err_cnt_d;
    logic         commit_go;
    logic         err_inc;
    logic         start;

    logic [1:0]   flag;
    logic [127:0] pay;
    logic         is_head;
    logic         is_tail;
    logic         hdr_bad;
    logic         unused_ok;

    assign flag      = in_data[133:132];
    assign pay       = in_data[127:0];
    assign unused_ok = ^in_data[131:128];
    assign is_head   = in_data_wr && (flag == 2'b01);
    assign is_tail   = in_data_wr && (flag == 2'b10);
    assign hdr_bad   = (pay[127:80] != in_local_mac_id)
                    || (pay[31:16] != ETHERTYPE)
                    || (pay[15:12] != RPT_TYPE);

    // A head word restarts parsing from any state still taking words
    assign start = is_head && (state_q == IDLE || state_q == RECV
                               || state_q == DISCARD);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bad_d     = bad_q;
        stg_d     = stg_q;
        commit_go = 1'b0;
        err_inc   = 1'b0;
        if (start) begin
            stg_d.smac = pay[79:32];
            cnt_d      = 3'd1;
            bad_d      = hdr_bad;
            err_inc    = (state_q != IDLE);
            state_d    = RECV;
        end else begin
            unique case (state_q)
                IDLE: ;
                RECV: begin
                    if (in_data_wr) begin
                        cnt_d = cnt_q + 3'd1;
                        case (cnt_q)
                            3'd1: {stg_d.esw_in, stg_d.esw_out} = pay;
                            3'd2: {stg_d.eos_in, stg_d.eos_out} = pay;
                            3'd3: {stg_d.goe_in, stg_d.goe_p0} = pay;
                            3'd4: {stg_d.goe_p1, stg_d.goe_dis} = pay;
                            3'd5: {stg_d.ts, stg_d.bufm, stg_d.q0,
                                   stg_d.q1, stg_d.q2, stg_d.q3} = pay[127:48];
                            default: ;
                        endcase
                        if (is_tail) begin
                            bad_d   = bad_q | (cnt_q != 3'd5);
                            state_d = WAIT_VALID;
                        end else if (cnt_q == 3'd5) begin
                            bad_d   = 1'b1;
                            state_d = DISCARD;
                        end
                    end
                end
                DISCARD: begin
                    if (is_tail) begin
                        state_d = WAIT_VALID;
                    end
                end
                WAIT_VALID: ;
                COMMIT:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        // valid_wr decides either with the tail word or while waiting
        if (in_data_valid_wr && state_d == WAIT_VALID) begin
            if (in_data_valid && !bad_d) begin
                commit_go = 1'b1;
                state_d   = COMMIT;
            end else begin
                err_inc = 1'b1;
                state_d = IDLE;
            end
        end
    end

    assign rpt_d     = commit_go ? stg_d : rpt_q;
    assign ok_cnt_d  = (commit_go && ok_cnt_q != '1)
                     ? ok_cnt_q + 32'd1 : ok_cnt_q;
    assign err_cnt_d = (err_inc && err_cnt_q != '1)
                     ? err_cnt_q + 32'd1 : err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bad_q     <= 1'b0;
            stg_q     <= '0;
            rpt_q     <= '0;
            ok_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bad_q     <= bad_d;
            stg_q     <= stg_d;
            rpt_q     <= rpt_d;
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pktin_ready      = (state_q != COMMIT);
    assign rpt_update       = (state_q == COMMIT);
    assign rpt_ok_cnt       = ok_cnt_q;
    assign rpt_err_cnt      = err_cnt_q;
    assign rpt_src_mac      = rpt_q.smac;
    assign rpt_timestamp    = rpt_q.ts;
    assign esw_pktin_cnt    = rpt_q.esw_in;
    assign esw_pktout_cnt   = rpt_q.esw_out;
    assign eos_mdin_cnt     = rpt_q.eos_in;
    assign eos_mdout_cnt    = rpt_q.eos_out;
    assign goe_pktin_cnt    = rpt_q.goe_in;
    assign goe_port0out_cnt = rpt_q.goe_p0;
    assign goe_port1out_cnt = rpt_q.goe_p1;
    assign goe_discard_cnt  = rpt_q.goe_dis;
    assign bufm_id_cnt      = rpt_q.bufm;
    assign eos_q0_used_cnt  = rpt_q.q0;
    assign eos_q1_used_cnt  = rpt_q.q1;
    assign eos_q2_used_cnt  = rpt_q.q2;
    assign eos_q3_used_cnt  = rpt_q.q3;

endmodule
